// File: rtl/led_pattern_sequencer_if.sv
// Signal bundle between the LED pattern sequencer and its board-level surroundings:
// raw buttons and run enable in, LED drive and status out.
interface led_pattern_sequencer_if #(
  parameter int NUM_LEDS = 8
);
  logic                btn_mode;
  logic                btn_speed;
  logic                enable;
  logic [NUM_LEDS-1:0] led;
  logic [1:0]          mode;
  logic [1:0]          speed;
  logic                step_tick;

  modport master (
    output btn_mode,
    output btn_speed,
    output enable,
    input  led,
    input  mode,
    input  speed,
    input  step_tick
  );

  modport slave (
    input  btn_mode,
    input  btn_speed,
    input  enable,
    output led,
    output mode,
    output speed,
    output step_tick
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED bank animator: two debounced buttons select one of four patterns and one of
// four step rates; the pattern advances once per step period while enabled.
module led_pattern_sequencer #(
  parameter int NUM_LEDS     = 8,
  parameter int TICK_MAX     = 50_000_000,
  parameter int DEBOUNCE_MAX = 1_000_000
) (
  input  logic                   sysclk,
  input  logic                   reset_n,
  led_pattern_sequencer_if.slave bus
);

  localparam int TW = $clog2(TICK_MAX + 1);
  localparam int DW = $clog2(DEBOUNCE_MAX + 1);

  localparam logic [DW-1:0]       DB_LAST    = DW'(DEBOUNCE_MAX - 1);
  localparam logic [DW-1:0]       DB_ONE     = DW'(1);
  localparam logic [DW-1:0]       DB_ZERO    = {DW{1'b0}};
  localparam logic [TW-1:0]       TICK_ONE   = TW'(1);
  localparam logic [TW-1:0]       TICK_ZERO  = {TW{1'b0}};
  localparam logic [31:0]         TICK_MAX_W = 32'(TICK_MAX);
  localparam logic [NUM_LEDS-1:0] LED_ALL    = {NUM_LEDS{1'b1}};
  localparam logic [NUM_LEDS-1:0] LED_NONE   = {NUM_LEDS{1'b0}};
  localparam logic [NUM_LEDS-1:0] LED_ONE    = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_BLINK  = 2'd0,
    ST_WALK   = 2'd1,
    ST_BOUNCE = 2'd2,
    ST_COUNT  = 2'd3
  } state_t;

  // Pattern loaded into the LED bank on entry to each mode.
  function automatic logic [NUM_LEDS-1:0] init_pattern(input state_t st);
    logic [NUM_LEDS-1:0] p;
    case (st)
      ST_BLINK:  p = LED_ALL;
      ST_WALK:   p = LED_ONE;
      ST_BOUNCE: p = LED_ONE;
      ST_COUNT:  p = LED_NONE;
      default:   p = LED_ALL;
    endcase
    return p;
  endfunction

  // Mode succession BLINK -> WALK -> BOUNCE -> COUNT -> BLINK.
  function automatic state_t next_mode(input state_t st);
    state_t n;
    case (st)
      ST_BLINK:  n = ST_WALK;
      ST_WALK:   n = ST_BOUNCE;
      ST_BOUNCE: n = ST_COUNT;
      ST_COUNT:  n = ST_BLINK;
      default:   n = ST_BLINK;
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------- buttons
  // Bit 0 is the mode button, bit 1 the speed button.
  logic [1:0]    btn_raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    stable_r;
  logic [1:0]    stable_d_r;
  logic [1:0]    press_r;
  logic [DW-1:0] db_cnt_r [2];

  assign btn_raw_s = {bus.btn_speed, bus.btn_mode};

  // Synchronize each raw button, accept a level after DEBOUNCE_MAX mismatches, pulse on rise.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r     <= 2'b00;
      sync2_r     <= 2'b00;
      stable_r    <= 2'b00;
      stable_d_r  <= 2'b00;
      press_r     <= 2'b00;
      db_cnt_r[0] <= DB_ZERO;
      db_cnt_r[1] <= DB_ZERO;
    end else begin
      sync1_r    <= btn_raw_s;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      press_r    <= stable_r & ~stable_d_r;
      for (int b = 0; b < 2; b++) begin
        if (sync2_r[b] == stable_r[b]) begin
          db_cnt_r[b] <= DB_ZERO;
        end else if (db_cnt_r[b] == DB_LAST) begin
          stable_r[b] <= ~stable_r[b];
          db_cnt_r[b] <= DB_ZERO;
        end else begin
          db_cnt_r[b] <= db_cnt_r[b] + DB_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------- sequencer
  state_t              state_r, state_s;
  logic [NUM_LEDS-1:0] led_r, led_s;
  logic [TW-1:0]       tick_cnt_r, tick_cnt_s;
  logic [1:0]          speed_r, speed_s;
  logic                dir_r, dir_s;          // 0 = moving left, 1 = moving right
  logic                step_tick_r, step_tick_s;
  logic                mode_press_s;
  logic                speed_press_s;
  logic [31:0]         period_s;
  logic                term_s;

  assign mode_press_s  = press_r[0];
  assign speed_press_s = press_r[1];
  assign period_s      = TICK_MAX_W >> speed_r;
  assign term_s        = (32'(tick_cnt_r) == (period_s - 32'd1));

  // State register and all registered outputs.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_BLINK;
      led_r       <= LED_ALL;
      tick_cnt_r  <= TICK_ZERO;
      speed_r     <= 2'd0;
      dir_r       <= 1'b0;
      step_tick_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      led_r       <= led_s;
      tick_cnt_r  <= tick_cnt_s;
      speed_r     <= speed_s;
      dir_r       <= dir_s;
      step_tick_r <= step_tick_s;
    end
  end

  // Next state: presses take priority over a step that falls on the same cycle.
  always_comb begin
    state_s     = state_r;
    led_s       = led_r;
    tick_cnt_s  = tick_cnt_r;
    speed_s     = speed_r;
    dir_s       = dir_r;
    step_tick_s = 1'b0;

    if (mode_press_s) begin
      state_s    = next_mode(state_r);
      led_s      = init_pattern(state_s);
      dir_s      = 1'b0;
      tick_cnt_s = TICK_ZERO;
    end else if (bus.enable && !speed_press_s && term_s) begin
      tick_cnt_s  = TICK_ZERO;
      step_tick_s = 1'b1;
      case (state_r)
        ST_BLINK: begin
          led_s = ~led_r;
        end
        ST_WALK: begin
          led_s = {led_r[NUM_LEDS-2:0], led_r[NUM_LEDS-1]};
        end
        ST_BOUNCE: begin
          // Direction flips on the step that lands on an end, so ends are not repeated.
          if (!dir_r) begin
            led_s = {led_r[NUM_LEDS-2:0], 1'b0};
            dir_s = led_r[NUM_LEDS-2];
          end else begin
            led_s = {1'b0, led_r[NUM_LEDS-1:1]};
            dir_s = ~led_r[1];
          end
        end
        ST_COUNT: begin
          led_s = led_r + LED_ONE;
        end
        default: begin
          led_s = LED_ALL;
        end
      endcase
    end else if (bus.enable && !speed_press_s) begin
      tick_cnt_s = tick_cnt_r + TICK_ONE;
    end else begin
      tick_cnt_s = tick_cnt_r;
    end

    if (speed_press_s) begin
      speed_s    = speed_r + 2'd1;
      tick_cnt_s = TICK_ZERO;
    end else begin
      speed_s = speed_r;
    end
  end

  assign bus.led       = led_r;
  assign bus.mode      = state_r;
  assign bus.speed     = speed_r;
  assign bus.step_tick = step_tick_r;

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller that sequences the board LED bank through selectable animation modes at selectable step rates.
- Two raw push-buttons drive it: one cycles the mode, one cycles the speed.
- Sits between the top-level clock buffer (differential sysclk already converted to single-ended) and the LED pins.
- Replaces the single fixed-rate blinker as the board's LED front end.

Parameters:
- NUM_LEDS, 8, width of LED bank; must be >= 2.
- TICK_MAX, 50_000_000, base step period in clocks at speed 0 (0.25 s at 200 MHz); must be >= 8.
- DEBOUNCE_MAX, 1_000_000, consecutive stable cycles required to accept a button level (5 ms at 200 MHz); must be >= 2.

Ports:
- sysclk  in  1  200 MHz single-ended system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw asynchronous mode button, active-high.
- btn_speed  in  1  raw asynchronous speed button, active-high.
- enable  in  1  synchronous run enable; low freezes animation.
- led  out  NUM_LEDS  LED drive, 1 = on.
- mode  out  2  current mode: 0 BLINK, 1 WALK, 2 BOUNCE, 3 COUNT.
- speed  out  2  current speed index, 0 slowest.
- step_tick  out  1  one-cycle pulse marking each pattern step.

Behaviour:
- Reset (async assert, sync release):
  - led = all ones; mode = 0; speed = 0; step_tick = 0.
  - Tick counter, debounce counters and synchronizers = 0; bounce direction = left.
  - Asserting reset_n mid-operation clears all state immediately, with no clock needed.
- Button path, per button:
  - 2-FF synchronizer feeds a debouncer.
  - Debounce counter increments while the synced level differs from the stable level; it clears whenever they match.
  - On the DEBOUNCE_MAX-th consecutive mismatch cycle, the stable level flips and the counter clears.
  - A stable 0->1 transition produces a registered 1-cycle press pulse. Release produces no pulse.
  - Any input shorter than DEBOUNCE_MAX cycles is ignored.
- Button latency: a clean raw rising edge changes the mode/speed output exactly DEBOUNCE_MAX+4 rising clock edges later. The bench allows ±1.
- Speed:
  - A speed press sets speed = speed+1 mod 4.
  - Step period P = TICK_MAX >> speed clocks.
  - A speed change clears the tick counter; the pattern is not reinitialised.
- Mode FSM, states BLINK -> WALK -> BOUNCE -> COUNT -> BLINK:
  - A mode press advances one state.
  - Entering a state loads its initial pattern into led and clears the tick counter.
  - Initial patterns: BLINK = all ones; WALK = 0...01; BOUNCE = 0...01 with direction left; COUNT = all zeros.
- Tick:
  - The counter runs 0..P-1 while enable = 1.
  - At terminal count the counter wraps to 0 and led advances one step on that edge.
  - step_tick is high for exactly the one cycle in which the new led value is first visible.
  - First step after reset or after any clear occurs P cycles later.
- Step rules:
  - BLINK: led = ~led.
  - WALK: rotate left; MSB wraps to LSB.
  - BOUNCE: shift one position in the current direction. On reaching the MSB the direction becomes right; on reaching the LSB it becomes left. No position repeats at the ends: 01,02,...,80,40,...,01,02.
  - COUNT: led+1 modulo 2^NUM_LEDS; all ones wraps to zero.
- enable = 0:
  - Tick counter and led hold; step_tick = 0.
  - Button presses are still accepted. A mode press still loads the initial pattern. A speed press still clears the counter.
- Simultaneous events:
  - Mode and speed presses in the same cycle both take effect.
  - A press coinciding with terminal count overrides the step: the initial pattern or clear wins, and no step_tick is issued.

Test Plan:
All scenarios use NUM_LEDS=8, TICK_MAX=16, DEBOUNCE_MAX=4.
- Release reset with enable=1 -> led FF; after 16 cycles led 00 with step_tick high 1 cycle; FF again 16 cycles later; mode=0, speed=0 throughout.
- One clean btn_mode press held 10 cycles -> mode=1 at edge 8±1, led 01; then 02,04,...,80,01 every 16 cycles.
- Two further presses -> mode 3 (COUNT), led 00,01,02...; hold through FF -> wraps to 00. Separately, in BOUNCE (mode 2) -> 01..80,40..01,02 every 16 cycles.
- Three btn_speed presses -> speed=3, step every 2 cycles; fourth press -> speed=0, step every 16 cycles; pattern uninterrupted across each change.
- btn_mode glitches of 1, 2 and 3 cycles, plus bouncy 0/1 toggling every 2 cycles -> mode unchanged; bounce settling high for 4+ cycles -> exactly one mode advance.
- COUNT at led 05: enable=0 for 50 cycles -> led holds 05, no step_tick; re-enable -> 06 after 16 cycles; drop reset_n mid-count -> led FF, mode 0, speed 0 with no clock edge.
